// File: rtl/id_inst_buffer.sv
// IF->ID instruction buffer: DEPTH-entry {pc, inst} FIFO with flush. Latency 1 cycle (0 with ID_BUF_BYPASS_EN when empty).
// Backpressure: in_ready drops only when full (registered, ignores same-cycle pop); out_ready low holds the head entry.
module id_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [PTR_W:0]    count
);

  localparam logic [0:0]     S_EMPTY    = 1'b0;
  localparam logic [0:0]     S_NONEMPTY = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [0:0]       state, state_nxt;
  logic             full, full_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt, cnt_nxt;

  logic byp_vld;
  logic take_byp;
  logic push;
  logic pop_mem;
  logic wr_en;
  logic rd_en;

  // Bypass presents the incoming pair on out_* only while nothing is stored.
`ifdef ID_BUF_BYPASS_EN
  assign byp_vld = (state == S_EMPTY) & in_valid & ~flush;
`else
  assign byp_vld = 1'b0;
`endif

  assign in_ready  = ~full;
  assign out_valid = (state == S_NONEMPTY) | byp_vld;
  assign count     = cnt;

  assign push     = in_valid & in_ready;
  assign pop_mem  = out_ready & (state == S_NONEMPTY);
  assign take_byp = byp_vld & out_ready;
  assign wr_en    = push & ~flush & ~take_byp;
  assign rd_en    = pop_mem & ~flush;

  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (state == S_NONEMPTY) begin
      out_pc   = pc_mem[rd_ptr];
      out_inst = inst_mem[rd_ptr];
    end else if (byp_vld) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   cnt_nxt = cnt + CNT_ONE;
        2'b01:   cnt_nxt = cnt - CNT_ONE;
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = (cnt_nxt != '0) ? S_NONEMPTY : S_EMPTY;
    full_nxt  = (cnt_nxt == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      state  <= S_EMPTY;
      full   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
      full  <= full_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is not reset; out_* masks stale contents through state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Bench for id_inst_buffer: directed test-plan sequences then random traffic against a queue model.
module tb_id_inst_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef ID_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   n_vec;
  int   n_bad;

  id_inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit byp_now();
    return BYP && (q.size() == 0) && in_valid && !flush;
  endfunction

  task automatic check_outputs();
    logic        e_vld;
    logic [31:0] e_pc, e_inst;
    e_vld  = (q.size() != 0) || byp_now();
    e_pc   = 32'h0;
    e_inst = 32'h0;
    if (q.size() != 0) begin
      e_pc   = q[0].pc;
      e_inst = q[0].inst;
    end else if (byp_now()) begin
      e_pc   = in_pc;
      e_inst = in_inst;
    end
    chk("count",     64'(count),     64'(q.size()));
    chk("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(e_vld));
    chk("out_pc",    64'(out_pc),    64'(e_pc));
    chk("out_inst",  64'(out_inst),  64'(e_inst));
  endtask

  task automatic model_step();
    int sz;
    bit popped, pushed;
    ent_t e;
    if (flush) begin
      q.delete();
    end else begin
      sz     = q.size();
      popped = out_ready && (sz > 0);
      pushed = in_valid && (sz < DEPTH);
      if (byp_now() && out_ready) pushed = 1'b0;
      e.pc   = in_pc;
      e.inst = in_inst;
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(e);
    end
  endtask

  task automatic cycle(input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = ins;
    out_ready = ordy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_inst   = 32'h0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // fill to full, then an ignored fifth push
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 32'hBFC00000 + 32'(4 * i), 32'h3401000A + 32'(i), 1'b0);
    cycle(1'b0, 1'b1, 32'hBFC00010, 32'h3401000E, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);

    // drain in order
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc", 64'(out_pc), 64'(32'hBFC00000 + 32'(4 * i)));
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // move pointers to 3, then hold two entries across the wrap
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 32'hBFC00100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b1, 32'hBFC00200 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 32'hBFC00300 + 32'(4 * i), 32'h3000 + 32'(i), 1'b1);
    chk("wrap_count", 64'(count), 64'd2);

    // flush priority with count=3
    cycle(1'b0, 1'b1, 32'hBFC00400, 32'h4000, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(1'b1, 1'b1, 32'hBFC00020, 32'h4020, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("post_flush_pc", 64'(out_pc), 64'd0);

    // bypass / one-cycle latency from empty
    cycle(1'b0, 1'b1, 32'hBFC00040, 32'h4040, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hBFC00044, 32'h4044, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 19) == 0), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) != 0));

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 32'hBFC00500 + 32'(4 * i), 32'h5000 + 32'(i), 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 40; i++)
      cycle(1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_inst_buffer.md
Name: id_inst_buffer

Overview:
- Parametrised instruction buffer between IF and ID, replacing the single IF->ID latch.
- Holds DEPTH entries of {pc, inst}, so ID no longer depends on instruction-SRAM read timing.
- Valid/ready handshake on both sides; flush on taken branch.
- ID decodes from the head entry; IF pushes fetched pc/inst pairs.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PTR_W, 2, log2(DEPTH); pointer width
- PC_W, 32, program-counter width
- INST_W, 32, instruction width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  discard all entries (taken branch from ID / br_bus br_e)
- in_valid  input  1  IF presents a fetched pair
- in_ready  output  1  buffer can accept a pair this cycle
- in_pc  input  PC_W  pc of fetched instruction
- in_inst  input  INST_W  fetched instruction word
- out_valid  output  1  head entry valid for ID
- out_ready  input  1  ID consumes head (low while ID stalls)
- out_pc  output  PC_W  head pc
- out_inst  output  INST_W  head instruction
- count  output  PTR_W+1  occupied entries, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry circular array plus wr_ptr, rd_ptr (PTR_W bits) and occupancy counter (PTR_W+1 bits). Pointers wrap from DEPTH-1 to 0.
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_pc=0, out_inst=0.
  - Entry contents need not be cleared.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state. A full buffer does not accept a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_pc and out_inst read the entry at rd_ptr combinationally. They are driven to 0 when out_valid=0.
- Latency: a push at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle pass-through (see Optional Feature).
- push only: write entry[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push & pop together: both pointers advance, count unchanged. Legal when 0 < count < DEPTH.
- flush = 1 at an edge: wr_ptr=0, rd_ptr=0, count=0. Flush has priority over any push or pop in the same cycle; the pushed pair is dropped. out_valid=0 in the following cycle.
- Order is strict FIFO; entries are never reordered or duplicated.
- Internal control is a two-state view, EMPTY (count==0) and NONEMPTY, plus a FULL flag. No other FSM state exists.
- Reset asserted mid-operation discards all contents immediately, asynchronously.

Optional Feature:
- Macro ID_BUF_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0, the input drives out_* combinationally.
  - out_valid=1, out_pc=in_pc, out_inst=in_inst.
  - If out_ready=1 that cycle, the pair is consumed with zero latency and not written; count stays 0.
  - If out_ready=0, it is written normally.
- Not defined: no combinational path from input to output. Minimum latency is 1 cycle; behaviour is exactly as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> count=0, out_valid=0, in_ready=1, out_pc=0.
- Fill/full:
  - Stimulus: out_ready=0; push pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C, with inst 0x3401000A..0x3401000D.
  - Required: count=4, in_ready=0. A fifth in_valid is ignored and count stays 4.
- Drain order: from the full state, out_ready=1 for 4 cycles -> out_pc sequence 0xBFC00000, ..04, ..08, ..0C, then out_valid=0 and count=0.
- Simultaneous push/pop with wrap:
  - Stimulus: count=2 with rd_ptr=3; push and pop every cycle for 6 cycles.
  - Required: count holds at 2, pointers wrap 3->0, output order matches input order.
- Flush priority:
  - Stimulus: count=3; assert flush together with in_valid (pc 0xBFC00020) and out_ready for one cycle.
  - Required: next cycle count=0, out_valid=0. Pc 0xBFC00020 never appears on the output.
- Bypass (ID_BUF_BYPASS_EN):
  - Empty, in_valid=1, in_pc=0xBFC00040, out_ready=1 -> same cycle out_valid=1, out_pc=0xBFC00040; count stays 0.
  - Without the macro: out_valid=0 that cycle, out_pc=0xBFC00040 appears the next cycle.
